ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard and checks the device acknowledge.
- Shares the PS2_CLK/PS2_DATA pins with the keyboard receive path.
- Asserts host_active while it owns the bus, so the receive path ignores bus activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 12000: clk cycles PS2_CLK is held low before the start bit (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: max clk cycles from releasing PS2_CLK to the end of the frame (20 ms).
- FILTER_LEN, 8: consecutive equal samples needed to accept a new PS2_CLK level.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset
- tx_data  input  8  command byte
- tx_valid  input  1  request to send tx_data
- tx_ready  output  1  high only in IDLE; transfer accepted when tx_valid && tx_ready
- tx_done  output  1  1-cycle pulse: frame sent and ACK received
- tx_err  output  1  1-cycle pulse: frame failed
- err_code  output  2  valid with tx_err: 01 timeout, 10 no ACK; holds its value until the next tx_err
- host_active  output  1  high in every state except IDLE
- PS2_CLK  inout  1  open-drain: drive 0 or Z, never 1
- PS2_DATA  inout  1  open-drain: drive 0 or Z, never 1

Behaviour:
- Reset (rst=0, asynchronous):
  - Both pins Z; state IDLE.
  - tx_ready=1; tx_done=0, tx_err=0, err_code=00, host_active=0.
  - Counters and shift register cleared.
  - Reset in the middle of a frame releases both pins immediately.
- Input conditioning:
  - PS2_CLK passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter.
  - fall = filtered-level 1->0 transition, one cycle wide.
  - PS2_DATA passes through a 2-flop synchronizer only.
- Frame content:
  - shift = {stop=1, parity=~^tx_data, tx_data[7:0]}, LSB first after the start bit.
  - Parity is odd.
- States:
  - IDLE:
    - Pins Z.
    - On accept: latch tx_data, load shift, clear counters, go INHIBIT next cycle.
    - tx_valid when tx_ready=0 is ignored; there is no queueing.
  - INHIBIT:
    - Drive PS2_CLK=0.
    - After INHIBIT_CYCLES cycles: drive PS2_DATA=0 (start bit), keep PS2_CLK=0 one more cycle, go REQ.
  - REQ:
    - Release PS2_CLK, keep PS2_DATA=0.
    - Start timeout counter; bit_cnt=0; go SEND.
  - SEND, on each fall:
    - bit_cnt 0..7: drive data bit bit_cnt (0 -> drive 0, 1 -> Z).
    - bit_cnt 8: drive parity.
    - bit_cnt 9: release PS2_DATA (stop).
    - bit_cnt increments on every fall. After the fall with bit_cnt=9, go ACK.
  - ACK:
    - On the next fall, sample synced PS2_DATA.
    - 0: go WAIT_IDLE.
    - 1: tx_err pulse, err_code=10, go IDLE.
  - WAIT_IDLE:
    - When filtered PS2_CLK=1 and synced PS2_DATA=1: tx_done pulse, go IDLE.
- Timeout:
  - Counter runs in REQ, SEND, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES: release both pins, tx_err pulse with err_code=01, go IDLE.
  - Timeout has priority over a fall in the same cycle.
- tx_done and tx_err are mutually exclusive. tx_ready returns high the cycle after either pulse.
- Latency from accept to first pin activity: PS2_CLK goes low 1 cycle after accept.

Test Plan:
- Test parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=5000, FILTER_LEN=4. Device model clocks at 1 falling edge per 200 cycles.
- Send 0xED:
  - PS2_CLK low for 20 cycles; start bit 0.
  - Device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Device ACK=0 -> exactly one tx_done pulse; err_code stays 00.
- Send 0xFF: parity bit 1 (eight ones, odd parity); ACK given -> tx_done. Host never drives a pin to 1; only 0/Z observed.
- Device model omits the ACK (DATA stays 1 at the 11th fall) -> tx_err pulse with err_code=10; pins Z; tx_ready=1 next cycle.
- Device never clocks after REQ -> tx_err pulse exactly 5000 cycles after PS2_CLK is released; err_code=01; both pins Z.
- Boundary cases:
  - tx_valid held high through a frame -> only one accept; a second frame starts after tx_done.
  - rst pulsed low during bit 4 -> pins Z within the same cycle; host_active=0; tx_done and tx_err never pulse.
- Glitch immunity: inject a 2-cycle low glitch on PS2_CLK during SEND -> bit_cnt is unchanged and the byte is received intact.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
// and checks the device acknowledge. It shares the open-drain PS2_CLK/PS2_DATA
// pins with the receive path. host_active tells the receive path to ignore the
// bus while this block owns it.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-low reset
//   tx_data      command byte to send
//   tx_valid     request to send tx_data (accepted when tx_valid && tx_ready)
//   tx_ready     high only while idle and able to accept
//   tx_done      1-cycle pulse: frame sent and ACK received
//   tx_err       1-cycle pulse: frame failed
//   err_code     01 timeout, 10 no ACK; holds until the next tx_err
//   host_active  high whenever a transfer is in progress
//   PS2_CLK      open-drain clock pin (driven 0 or Z)
//   PS2_DATA     open-drain data pin (driven 0 or Z)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  output logic       host_active,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  // ST_START is the extra cycle with the start bit driven and PS2_CLK still low.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_REQ       = 3'd3,
    ST_SEND      = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_t;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

  state_t           state_r, state_s;
  logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic             clk_filt_r, fall_r;
  logic [FLT_W-1:0] flt_cnt_r;
  logic [9:0]       shift_r;
  logic [3:0]       bit_cnt_r;
  logic [INH_W-1:0] inh_cnt_r;
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             clk_oe_r, data_oe_r, clk_oe_s, data_oe_s;
  logic             tx_ready_r, tx_done_r, tx_err_r, host_active_r;
  logic             tx_ready_s, tx_done_s, tx_err_s, host_active_s;
  logic [1:0]       err_code_r, err_code_s;
  logic             accept_s, inh_done_s, tmo_hit_s, counting_s, no_ack_s, tmo_err_s;

  assign accept_s   = tx_valid && tx_ready_r;
  assign inh_done_s = (inh_cnt_r == INH_LAST);
  assign tmo_hit_s  = (tmo_cnt_r == TMO_LAST);
  assign counting_s = (state_r == ST_REQ) || (state_r == ST_SEND) ||
                      (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);

  // Open-drain pins: only ever pull low or release.
  assign PS2_CLK  = clk_oe_r  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_oe_r ? 1'b0 : 1'bz;

  assign tx_ready    = tx_ready_r;
  assign tx_done     = tx_done_r;
  assign tx_err      = tx_err_r;
  assign err_code    = err_code_r;
  assign host_active = host_active_r;

  // Pin synchronizers and PS2_CLK glitch filter; fall_r marks a filtered 1->0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      clk_filt_r  <= 1'b1;
      flt_cnt_r   <= '0;
      fall_r      <= 1'b0;
    end else begin
      clk_meta_r  <= PS2_CLK;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= PS2_DATA;
      data_sync_r <= data_meta_r;
      fall_r      <= 1'b0;
      if (clk_sync_r == clk_filt_r) begin
        flt_cnt_r <= '0;
      end else if (flt_cnt_r == FLT_LAST) begin
        clk_filt_r <= clk_sync_r;
        flt_cnt_r  <= '0;
        fall_r     <= clk_filt_r;  // old level 1 means the new level is 0
      end else begin
        flt_cnt_r <= flt_cnt_r + FLT_W'(1);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the timeout wins over a clock fall in the same cycle.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:      if (accept_s) state_s = ST_INHIBIT; else state_s = ST_IDLE;
      ST_INHIBIT:   if (inh_done_s) state_s = ST_START; else state_s = ST_INHIBIT;
      ST_START:     state_s = ST_REQ;
      ST_REQ:       if (tmo_hit_s) state_s = ST_IDLE; else state_s = ST_SEND;
      ST_SEND: begin
        if (tmo_hit_s)                         state_s = ST_IDLE;
        else if (fall_r && bit_cnt_r == 4'd9)  state_s = ST_ACK;
        else                                   state_s = ST_SEND;
      end
      ST_ACK: begin
        if (tmo_hit_s)   state_s = ST_IDLE;
        else if (fall_r) state_s = data_sync_r ? ST_IDLE : ST_WAIT_IDLE;
        else             state_s = ST_ACK;
      end
      ST_WAIT_IDLE: begin
        if (tmo_hit_s)                       state_s = ST_IDLE;
        else if (clk_filt_r && data_sync_r)  state_s = ST_IDLE;
        else                                 state_s = ST_WAIT_IDLE;
      end
      default:      state_s = ST_IDLE;
    endcase
  end

  // Next values of all registered outputs and pin enables.
  always_comb begin
    tmo_err_s     = counting_s && tmo_hit_s;
    no_ack_s      = (state_r == ST_ACK) && !tmo_hit_s && fall_r && data_sync_r;
    tx_done_s     = (state_r == ST_WAIT_IDLE) && !tmo_hit_s && clk_filt_r && data_sync_r;
    tx_err_s      = tmo_err_s || no_ack_s;
    if (tmo_err_s)     err_code_s = 2'b01;
    else if (no_ack_s) err_code_s = 2'b10;
    else               err_code_s = err_code_r;
    // tx_ready stays low during the result pulse and rises the cycle after.
    tx_ready_s    = (state_s == ST_IDLE) && !tx_done_s && !tx_err_s;
    host_active_s = (state_s != ST_IDLE);
    clk_oe_s      = (state_s == ST_INHIBIT) || (state_s == ST_START);
    if ((state_s == ST_IDLE) || (state_s == ST_INHIBIT))     data_oe_s = 1'b0;
    else if ((state_s == ST_START) || (state_s == ST_REQ))   data_oe_s = 1'b1;
    else if ((state_r == ST_SEND) && fall_r)                 data_oe_s = ~shift_r[0];
    else if (state_s == ST_SEND)                             data_oe_s = data_oe_r;
    else                                                     data_oe_s = 1'b0;
  end

  // Output and pin-enable registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_ready_r    <= 1'b1;
      tx_done_r     <= 1'b0;
      tx_err_r      <= 1'b0;
      err_code_r    <= 2'b00;
      host_active_r <= 1'b0;
      clk_oe_r      <= 1'b0;
      data_oe_r     <= 1'b0;
    end else begin
      tx_ready_r    <= tx_ready_s;
      tx_done_r     <= tx_done_s;
      tx_err_r      <= tx_err_s;
      err_code_r    <= err_code_s;
      host_active_r <= host_active_s;
      clk_oe_r      <= clk_oe_s;
      data_oe_r     <= data_oe_s;
    end
  end

  // Frame shift register, bit counter, inhibit and timeout counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_r   <= '0;
      bit_cnt_r <= 4'd0;
      inh_cnt_r <= '0;
      tmo_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            shift_r   <= {1'b1, odd_parity(tx_data), tx_data};
            bit_cnt_r <= 4'd0;
            inh_cnt_r <= '0;
            tmo_cnt_r <= '0;
          end
        end
        ST_INHIBIT: inh_cnt_r <= inh_cnt_r + INH_W'(1);
        ST_START:   tmo_cnt_r <= '0;
        ST_REQ: begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          bit_cnt_r <= 4'd0;
        end
        ST_SEND: begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          if (fall_r && !tmo_hit_s) begin
            shift_r   <= {1'b1, shift_r[9:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        ST_ACK, ST_WAIT_IDLE: tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        default: begin
          bit_cnt_r <= 4'd0;
          tmo_cnt_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  localparam int INH  = 20;
  localparam int TMO  = 5000;
  localparam int FLT  = 4;
  localparam int HALF = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, host_active;
  logic [1:0] err_code;
  wire        ps2_clk, ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0;
  bit pulse_prev = 1'b0;
  logic [1:0] exp_code = 2'b00;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_err(tx_err), .err_code(err_code),
    .host_active(host_active), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference frame as the device should see it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  // Pulse monitor: counts results and checks tx_ready the cycle after a pulse.
  always @(negedge clk) begin
    if (pulse_prev) check("ready_after_pulse", 32'(tx_ready), 32'd1);
    if (tx_done || tx_err) check("done_err_excl", 32'(tx_done & tx_err), 32'd0);
    if (tx_done) done_cnt++;
    if (tx_err)  err_cnt++;
    pulse_prev = tx_done | tx_err;
  end

  // Accept counter, sampled on the edge the DUT itself uses.
  always @(posedge clk) begin
    if (tx_valid && tx_ready) acc_cnt++;
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    check("ready_before_tx", 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("active_after_accept", 32'(host_active), 32'd1);
    check("clk_low_after_accept", 32'(ps2_clk), 32'd0);
  endtask

  task automatic wait_release();
    int g = 0;
    while (ps2_clk === 1'b0 && g < 1000) begin @(negedge clk); g++; end
    check("clk_released", 32'(ps2_clk), 32'd1);
  endtask

  // Device model: measures inhibit, clocks 10 bits, optional ACK and glitch.
  task automatic dev_frame(input bit give_ack, input int glitch_bit,
                           output logic [10:0] rx, output int inh_a, output int inh_b);
    int g = 0;
    rx = '0; inh_a = 0; inh_b = 0;
    while (ps2_clk !== 1'b0 && g < 1000) begin @(negedge clk); g++; end
    check("inhibit_seen", 32'(ps2_clk), 32'd0);
    g = 0;
    while (ps2_clk === 1'b0 && g < 1000) begin
      if (ps2_data === 1'b1) inh_a++; else inh_b++;
      @(negedge clk); g++;
    end
    check("clk_released", 32'(ps2_clk), 32'd1);
    rx[0] = ps2_data;
    repeat (50) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      rx[i] = ps2_data;
      dev_clk_low = 1'b0;
      if (glitch_bit == i) begin
        repeat (40) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 42) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (give_ack) dev_data_low = 1'b1;
    repeat (20) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_outcome(input int d0, input int e0);
    int g = 0;
    while (done_cnt == d0 && err_cnt == e0 && g < 500) begin @(negedge clk); g++; end
    check("outcome_seen", 32'(g < 500), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] b, input bit ack, input int glitch);
    logic [10:0] rx;
    int a, bb, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(b);
    dev_frame(ack, glitch, rx, a, bb);
    check("inhibit_len", 32'(a), 32'(INH));
    check("start_hold", 32'(bb), 32'd1);
    check("frame_bits", 32'(rx), 32'(exp_frame(b)));
    wait_outcome(d0, e0);
    if (!ack) exp_code = 2'b10;
    check("done_delta", 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
    check("err_delta", 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
    check("err_code", 32'(err_code), 32'(exp_code));
    check("clk_idle", 32'(ps2_clk), 32'd1);
    check("data_idle", 32'(ps2_data), 32'd1);
    check("ready_idle", 32'(tx_ready), 32'd1);
    check("active_idle", 32'(host_active), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] rx;
    logic [7:0]  b;
    int a, bb, d0, e0, a0, n, g;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    check("rst_code", 32'(err_code), 32'd0);
    check("rst_active", 32'(host_active), 32'd0);
    check("rst_clk_z", 32'(ps2_clk), 32'd1);
    check("rst_data_z", 32'(ps2_data), 32'd1);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    do_frame(8'hED, 1'b1, 0);
    do_frame(8'hFF, 1'b1, 0);
    for (int k = 0; k < 4; k++) do_frame(8'($urandom), 1'b1, (k == 1) ? 4 : 0);

    // Missing ACK
    do_frame(8'($urandom), 1'b0, 0);

    // Device never clocks: timeout measured from PS2_CLK release
    e0 = err_cnt;
    start_tx(8'($urandom));
    wait_release();
    n = 0;
    while (!tx_err && n < TMO + 100) begin @(negedge clk); n++; end
    exp_code = 2'b01;
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("timeout_code", 32'(err_code), 32'(exp_code));
    @(negedge clk);
    check("timeout_err_cnt", 32'(err_cnt - e0), 32'd1);
    check("timeout_clk_z", 32'(ps2_clk), 32'd1);
    check("timeout_data_z", 32'(ps2_data), 32'd1);
    repeat (5) @(negedge clk);

    // tx_valid held through a frame: one accept per frame
    b = 8'($urandom);
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    dev_frame(1'b1, 0, rx, a, bb);
    check("held_frame1", 32'(rx), 32'(exp_frame(b)));
    g = 0;
    while (done_cnt == d0 && g < 500) begin @(negedge clk); g++; end
    check("held_done1", 32'(done_cnt - d0), 32'd1);
    g = 0;
    while (!host_active && g < 50) begin @(negedge clk); g++; end
    tx_valid = 1'b0;
    check("held_second_start", 32'(host_active), 32'd1);
    dev_frame(1'b1, 0, rx, a, bb);
    check("held_frame2", 32'(rx), 32'(exp_frame(b)));
    wait_outcome(d0 + 1, e0);
    repeat (50) @(negedge clk);
    check("held_done_total", 32'(done_cnt - d0), 32'd2);
    check("held_accepts", 32'(acc_cnt - a0), 32'd2);

    // Reset during bit 4 (bit 4 forced to 0 so the host is driving DATA low)
    b = 8'($urandom) & 8'hEF;
    d0 = done_cnt; e0 = err_cnt;
    start_tx(b);
    wait_release();
    repeat (50) @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (i < 5) repeat (HALF) @(negedge clk);
    end
    repeat (50) @(negedge clk);
    check("bit4_driven", 32'(ps2_data), 32'd0);
    rst = 1'b0;
    #1;
    exp_code = 2'b00;
    check("midrst_data_z", 32'(ps2_data), 32'd1);
    check("midrst_clk_z", 32'(ps2_clk), 32'd1);
    check("midrst_active", 32'(host_active), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    check("midrst_code", 32'(err_code), 32'(exp_code));
    @(negedge clk);
    rst = 1'b1;
    repeat (HALF) @(negedge clk);
    for (int i = 6; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    repeat (300) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_no_err", 32'(err_cnt - e0), 32'd0);
    check("midrst_idle_ready", 32'(tx_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
